// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions (FSM states, default width, parity encoding)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int DATA_WIDTH_DEF = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - per-bit edge counter with mid-bit 2-of-3 majority vote
module uart_rx_sampler #(
  parameter int PRESCALE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  input  logic i_rx,
  output logic o_decide,
  output logic o_bit,
  output logic o_bit_end
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] SMP_LO = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] SMP_MID = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] SMP_HI = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] r_edge_cnt;
  logic          r_s0;
  logic          r_s1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_edge_cnt <= '0;
      r_s0       <= 1'b0;
      r_s1       <= 1'b0;
    end else if (i_clear) begin
      r_edge_cnt <= '0;
    end else if (i_en) begin
      r_edge_cnt <= (r_edge_cnt == CNT_LAST) ? '0 : r_edge_cnt + 1'b1;
      if (r_edge_cnt == SMP_LO) r_s0 <= i_rx;
      if (r_edge_cnt == SMP_MID) r_s1 <= i_rx;
    end
  end

  // Third sample is the live line value, so the vote resolves in the decision cycle itself.
  assign o_bit     = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);
  assign o_decide  = i_en && (r_edge_cnt == SMP_HI);
  assign o_bit_end = i_en && (r_edge_cnt == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: synchronizer, framing FSM, parity/stop checks
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int PRESCALE   = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR,
  output logic                  busy
);

  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  uart_state_e r_state;
  uart_state_e w_next;

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_sync_prev;
  logic [BW-1:0]         r_bit_cnt;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_par_mis;
  logic [DATA_WIDTH-1:0] r_p_data;
  logic                  r_data_valid;
  logic                  r_par_err;
  logic                  r_stp_err;
  logic                  r_busy;

  logic w_fall;
  logic w_clear;
  logic w_en;
  logic w_decide;
  logic w_bit;
  logic w_bit_end;
  logic w_exp_par;

  assign w_fall    = r_sync_prev & ~r_sync2;
  assign w_en      = (r_state != IDLE);
  assign w_exp_par = (^r_shift) ^ (r_par_typ == PAR_ODD);

  uart_rx_sampler #(
    .PRESCALE(PRESCALE)
  ) u_sampler (
    .clk      (CLK),
    .rst_n    (RST),
    .i_clear  (w_clear),
    .i_en     (w_en),
    .i_rx     (r_sync2),
    .o_decide (w_decide),
    .o_bit    (w_bit),
    .o_bit_end(w_bit_end)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_next  = START;
          w_clear = 1'b1;
        end
      end
      START: begin
        if (w_decide && w_bit) w_next = IDLE;
        else if (w_bit_end)    w_next = DATA;
      end
      DATA: begin
        if (w_decide && (r_bit_cnt == LAST_BIT)) w_next = r_par_en ? PARITY : STOP;
      end
      PARITY: begin
        if (w_decide) w_next = STOP;
      end
      // Leaves at mid-bit so a start edge in the back half of the stop bit is caught.
      STOP: begin
        if (w_decide) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_sync1      <= 1'b1;
      r_sync2      <= 1'b1;
      r_sync_prev  <= 1'b1;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_en     <= 1'b0;
      r_par_typ    <= 1'b0;
      r_par_mis    <= 1'b0;
      r_p_data     <= '0;
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_sync1      <= RX_IN;
      r_sync2      <= r_sync1;
      r_sync_prev  <= r_sync2;
      r_busy       <= (w_next != IDLE);
      r_data_valid <= 1'b0;
      r_par_err    <= 1'b0;
      r_stp_err    <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_fall) begin
            r_bit_cnt <= '0;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_par_mis <= 1'b0;
          end
        end
        DATA: begin
          if (w_decide) begin
            r_shift   <= {r_shift[DATA_WIDTH-2:0], w_bit};
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          if (w_decide) r_par_mis <= (w_bit != w_exp_par);
        end
        STOP: begin
          if (w_decide) begin
            r_stp_err <= ~w_bit;
            r_par_err <= r_par_mis;
            if (w_bit && !r_par_mis) begin
              r_p_data     <= r_shift;
              r_data_valid <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign P_DATA     = r_p_data;
  assign DATA_VALID = r_data_valid;
  assign PAR_ERR    = r_par_err;
  assign STP_ERR    = r_stp_err;
  assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard bench for uart_rx with directed and random frames
module tb_uart_rx;

  localparam int P = 8;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;
  logic       busy;

  uart_rx #(
    .DATA_WIDTH(8),
    .PRESCALE  (P)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RX_IN     (RX_IN),
    .PAR_EN    (PAR_EN),
    .PAR_TYP   (PAR_TYP),
    .P_DATA    (P_DATA),
    .DATA_VALID(DATA_VALID),
    .PAR_ERR   (PAR_ERR),
    .STP_ERR   (STP_ERR),
    .busy      (busy)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [7:0] word;
    logic       dv;
    logic       pe;
    logic       se;
    int         at;
  } exp_t;

  exp_t       q[$];
  exp_t       e_m;
  logic [7:0] model_word = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Any flag cycle is matched against the oldest outstanding frame expectation.
  always @(negedge CLK) begin
    if (RST === 1'b1 && (DATA_VALID || PAR_ERR || STP_ERR)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e_m = q.pop_front();
        check("data_valid", DATA_VALID, e_m.dv);
        check("par_err", PAR_ERR, e_m.pe);
        check("stp_err", STP_ERR, e_m.se);
        check("p_data", P_DATA, e_m.word);
        check("flag_cycle", cyc, e_m.at);
        check("busy_low_at_flag", busy, 0);
      end
    end
  end

  task automatic drive_bit(input logic v, input int n);
    RX_IN = v;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Model: frame error rules applied to the stimulus itself; flag time from the frame length.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input logic flip, input logic stop_v, input int stop_len,
                            input logic twiddle);
    int   n0;
    int   nbits;
    logic pbit;
    logic pe;
    logic se;
    exp_t ex;
    n0      = cyc;
    PAR_EN  = pen;
    PAR_TYP = ptyp;
    pbit    = ((^d) ^ ptyp) ^ flip;
    pe      = pen && flip;
    se      = !stop_v;
    if (!pe && !se) model_word = d;
    nbits   = 1 + 8 + (pen ? 1 : 0) + 1;
    ex.word = model_word;
    ex.dv   = !pe && !se;
    ex.pe   = pe;
    ex.se   = se;
    ex.at   = n0 + 1 + (nbits - 1) * P + P / 2 + 4;
    q.push_back(ex);
    drive_bit(1'b0, P);
    check("busy_in_frame", busy, 1);
    for (int i = 7; i >= 0; i--) begin
      drive_bit(d[i], P);
      if (twiddle && i == 4) begin
        PAR_EN  = 1'($urandom_range(0, 1));
        PAR_TYP = 1'($urandom_range(0, 1));
      end
    end
    if (pen) drive_bit(pbit, P);
    drive_bit(stop_v, stop_len);
  endtask

  initial begin
    RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_p_data", P_DATA, 0);
    check("rst_valid", DATA_VALID, 0);
    check("rst_par_err", PAR_ERR, 0);
    check("rst_stp_err", STP_ERR, 0);
    check("rst_busy", busy, 0);
    RST = 1'b1;
    drive_bit(1'b1, P);

    send_frame(8'hF9, 1'b0, 1'b0, 1'b0, 1'b1, P, 1'b0);
    drive_bit(1'b1, 2 * P);
    send_frame(8'hF9, 1'b1, 1'b1, 1'b0, 1'b1, P, 1'b0);
    drive_bit(1'b1, 2 * P);
    send_frame(8'h12, 1'b1, 1'b1, 1'b1, 1'b1, P, 1'b1);
    drive_bit(1'b1, 2 * P);
    send_frame(8'hF9, 1'b1, 1'b0, 1'b0, 1'b1, P, 1'b0);
    drive_bit(1'b1, 2 * P);
    // Stop error with the line left low: must not be taken as a new start.
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, P, 1'b0);
    drive_bit(1'b0, 3 * P);
    drive_bit(1'b1, 2 * P);

    drive_bit(1'b0, 3);
    drive_bit(1'b1, 1);
    begin
      int k;
      k = 0;
      while (busy !== 1'b0 && k < 8) begin
        @(posedge CLK);
        #1;
        k++;
      end
      check("glitch_busy_clear", busy, 0);
    end
    drive_bit(1'b1, P);
    send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, P, 1'b0);
    drive_bit(1'b1, 2 * P);

    send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 7, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, P, 1'b0);
    drive_bit(1'b1, 2 * P);

    PAR_EN = 1'b0;
    drive_bit(1'b0, P);
    drive_bit(1'b0, P);
    drive_bit(1'b1, P);
    drive_bit(1'b1, P);
    drive_bit(1'b0, P);
    drive_bit(1'b1, 4);
    RST = 1'b0;
    #1;
    check("abort_p_data", P_DATA, 0);
    check("abort_valid", DATA_VALID, 0);
    check("abort_par_err", PAR_ERR, 0);
    check("abort_stp_err", STP_ERR, 0);
    check("abort_busy", busy, 0);
    model_word = 8'h00;
    RX_IN = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b1;
    drive_bit(1'b1, P);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, P, 1'b0);
    drive_bit(1'b1, 2 * P);

    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      logic       pen;
      logic       ptyp;
      logic       flip;
      logic       stop_v;
      d      = 8'($urandom);
      pen    = 1'($urandom_range(0, 1));
      ptyp   = 1'($urandom_range(0, 1));
      flip   = ($urandom_range(0, 3) == 0);
      stop_v = ($urandom_range(0, 5) != 0);
      if (stop_v) begin
        send_frame(d, pen, ptyp, flip, 1'b1, $urandom_range(7, 8), 1'($urandom_range(0, 1)));
        drive_bit(1'b1, $urandom_range(0, 5));
      end else begin
        send_frame(d, pen, ptyp, flip, 1'b0, P, 1'($urandom_range(0, 1)));
        drive_bit(1'b0, $urandom_range(0, P));
        drive_bit(1'b1, 2 * P);
      end
    end
    drive_bit(1'b1, 2 * P);

    for (int i = 0; i < 200 && q.size() != 0; i++) @(posedge CLK);
    #1;
    check("queue_drained", q.size(), 0);
    check("final_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
